// File: rtl/sodor_mem_pkg.sv
// Memory-command encodings and responder FSM states, shared with the
// core-side decode.
package sodor_mem_pkg;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fcn;
        logic [2:0]  typ;
    } dmem_req_t;

endpackage

// File: rtl/sodor_dmem_lane_align.sv
// Byte-lane steering: store byte-enables/shift and load extract/extend,
// plus typ legality and alignment checks.
module sodor_dmem_lane_align
    import sodor_mem_pkg::*;
(
    input  logic [2:0]  typ,
    input  logic [1:0]  lane,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic        typ_ok,
    output logic        misaligned,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data
);

    logic [4:0]  shamt;
    logic [31:0] lane_data;

    assign shamt     = {lane, 3'b000};
    assign wr_word   = st_data << shamt;
    assign lane_data = rd_word >> shamt;

    always_comb begin
        typ_ok     = 1'b1;
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        ld_data    = 32'h0;
        unique case (typ)
            MT_B: begin
                byte_en = 4'b0001 << lane;
                ld_data = {{24{lane_data[7]}}, lane_data[7:0]};
            end
            MT_BU: begin
                byte_en = 4'b0001 << lane;
                ld_data = {24'h0, lane_data[7:0]};
            end
            MT_H: begin
                misaligned = lane[0];
                byte_en    = 4'b0011 << lane;
                ld_data    = {{16{lane_data[15]}}, lane_data[15:0]};
            end
            MT_HU: begin
                misaligned = lane[0];
                byte_en    = 4'b0011 << lane;
                ld_data    = {16'h0, lane_data[15:0]};
            end
            MT_W: begin
                misaligned = (lane != 2'b00);
                byte_en    = 4'b1111;
                ld_data    = rd_word;
            end
            default: typ_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/sodor_dmem_responder.sv
// Fixed-latency, single-outstanding data-memory responder with
// byte-lane access, range/alignment checking and last-load tracking.
module sodor_dmem_responder
    import sodor_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_dmem_req_valid,
    output logic        io_dmem_req_ready,
    input  logic [31:0] io_dmem_req_bits_addr,
    input  logic [31:0] io_dmem_req_bits_data,
    input  logic        io_dmem_req_bits_fcn,
    input  logic [2:0]  io_dmem_req_bits_typ,
    output logic        io_dmem_resp_valid,
    input  logic        io_dmem_resp_ready,
    output logic [31:0] io_dmem_resp_bits_data,
    output logic        io_dmem_resp_bits_err,
    output logic        port_last_load_valid,
    output logic [31:0] port_last_load_addr
);

    localparam int          IW         = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  CNT_LOAD   = 2'(LATENCY - 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

    dmem_state_e state, next_state;
    dmem_req_t   req_q;
    logic [1:0]  cnt_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic [IW-1:0] idx;
    logic          typ_ok;
    logic          misaligned;
    logic [3:0]    byte_en;
    logic [31:0]   wr_word;
    logic [31:0]   ld_data;
    logic          err_c;
    logic          accept;
    logic          access;
    logic          do_write;
    logic          load_ok;

    assign idx      = req_q.addr[IW+1:2];
    assign accept   = (state == S_IDLE) && io_dmem_req_valid;
    assign access   = (state == S_WAIT) && (cnt_q == 2'd0);
    assign err_c    = (req_q.addr >= ADDR_LIMIT) | misaligned | ~typ_ok;
    assign do_write = access && (req_q.fcn == M_XWR) && !err_c;
    assign load_ok  = access && (req_q.fcn == M_XRD) && !err_c;

    sodor_dmem_lane_align u_align (
        .typ        (req_q.typ),
        .lane       (req_q.addr[1:0]),
        .st_data    (req_q.data),
        .rd_word    (mem[idx]),
        .typ_ok     (typ_ok),
        .misaligned (misaligned),
        .byte_en    (byte_en),
        .wr_word    (wr_word),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (io_dmem_req_valid) next_state = S_WAIT;
            S_WAIT:  if (cnt_q == 2'd0) next_state = S_RESP;
            S_RESP:  if (io_dmem_resp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        io_dmem_req_ready  = (state == S_IDLE);
        io_dmem_resp_valid = (state == S_RESP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q                  <= '0;
            cnt_q                  <= 2'd0;
            io_dmem_resp_bits_data <= 32'h0;
            io_dmem_resp_bits_err  <= 1'b0;
            port_last_load_valid   <= 1'b0;
            port_last_load_addr    <= 32'h0;
        end else begin
            if (accept) begin
                req_q.addr <= io_dmem_req_bits_addr;
                req_q.data <= io_dmem_req_bits_data;
                req_q.fcn  <= io_dmem_req_bits_fcn;
                req_q.typ  <= io_dmem_req_bits_typ;
                cnt_q      <= CNT_LOAD;
            end else if (state == S_WAIT && cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (access) begin
                io_dmem_resp_bits_err  <= err_c;
                io_dmem_resp_bits_data <= load_ok ? ld_data : 32'h0;
            end
            if (load_ok) begin
                port_last_load_valid <= 1'b1;
                port_last_load_addr  <= req_q.addr;
            end
        end
    end

    // Memory clears on reset so an abandoned store can never leave residue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sodor_dmem_responder.sv
// Directed bench for sodor_dmem_responder (DEPTH_WORDS=16, LATENCY=2).
module tb_sodor_dmem_responder;
    import sodor_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        req_fcn = 1'b0;
    logic [2:0]  req_typ = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        ll_valid;
    logic [31:0] ll_addr;

    int n_checks = 0;
    int n_fail   = 0;

    sodor_dmem_responder #(.DEPTH_WORDS(16), .LATENCY(2)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_dmem_req_valid      (req_valid),
        .io_dmem_req_ready      (req_ready),
        .io_dmem_req_bits_addr  (req_addr),
        .io_dmem_req_bits_data  (req_data),
        .io_dmem_req_bits_fcn   (req_fcn),
        .io_dmem_req_bits_typ   (req_typ),
        .io_dmem_resp_valid     (resp_valid),
        .io_dmem_resp_ready     (resp_ready),
        .io_dmem_resp_bits_data (resp_data),
        .io_dmem_resp_bits_err  (resp_err),
        .port_last_load_valid   (ll_valid),
        .port_last_load_addr    (ll_addr)
    );

    always #5 clock = ~clock;

    // One full transaction; lat counts edges from acceptance to resp_valid.
    task automatic do_req(input logic fcn, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic [31:0] rdata,
                          output logic rerr);
        req_valid = 1'b1;
        req_fcn   = fcn;
        req_typ   = typ;
        req_addr  = addr;
        req_data  = data;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
        rdata = resp_data;
        rerr  = resp_err;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++;
        if (resp_data !== 32'h0 || resp_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_resp: got %h/%b want 0/0", resp_data, resp_err); end
        n_checks++;
        if (ll_valid !== 1'b0 || ll_addr !== 32'h0) begin n_fail++;
            $display("FAIL reset_last_load: got %b/%h want 0/0", ll_valid, ll_addr); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_word();
        int lat; logic [31:0] d; logic e;
        do_req(M_XWR, MT_W, 32'h8, 32'hDEADBEEF, lat, d, e);
        n_checks++;
        if (lat != 2) begin n_fail++;
            $display("FAIL store_w_latency: got %0d want 2", lat); end
        n_checks++;
        if (d !== 32'h0 || e !== 1'b0) begin n_fail++;
            $display("FAIL store_w_resp: got %h/%b want 0/0", d, e); end
        n_checks++;
        if (ll_valid !== 1'b0) begin n_fail++;
            $display("FAIL store_no_last_load: got %b want 0", ll_valid); end
        do_req(M_XRD, MT_W, 32'h8, 32'h0, lat, d, e);
        n_checks++;
        if (lat != 2) begin n_fail++;
            $display("FAIL load_w_latency: got %0d want 2", lat); end
        n_checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++;
            $display("FAIL load_w_data: got %h/%b want deadbeef/0", d, e); end
        n_checks++;
        if (ll_valid !== 1'b1 || ll_addr !== 32'h8) begin n_fail++;
            $display("FAIL load_w_last: got %b/%h want 1/8", ll_valid, ll_addr); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL idle_after_resp: got %b want 1", req_ready); end
    endtask

    task automatic test_subword_load();
        int lat; logic [31:0] d; logic e;
        do_req(M_XRD, MT_B, 32'hB, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'hFFFFFFDE || e !== 1'b0) begin n_fail++;
            $display("FAIL load_b: got %h/%b want ffffffde/0", d, e); end
        do_req(M_XRD, MT_BU, 32'hB, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h000000DE) begin n_fail++;
            $display("FAIL load_bu: got %h want 000000de", d); end
        do_req(M_XRD, MT_H, 32'h8, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'hFFFFBEEF) begin n_fail++;
            $display("FAIL load_h: got %h want ffffbeef", d); end
        do_req(M_XRD, MT_HU, 32'hA, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h0000DEAD) begin n_fail++;
            $display("FAIL load_hu: got %h want 0000dead", d); end
        n_checks++;
        if (ll_addr !== 32'hA) begin n_fail++;
            $display("FAIL last_addr_hu: got %h want a", ll_addr); end
    endtask

    task automatic test_subword_store();
        int lat; logic [31:0] d; logic e;
        do_req(M_XWR, MT_H, 32'hE, 32'hFFFFCAFE, lat, d, e);
        do_req(M_XWR, MT_B, 32'hD, 32'hAAAAAA12, lat, d, e);
        do_req(M_XRD, MT_W, 32'hC, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'hCAFE1200 || e !== 1'b0) begin n_fail++;
            $display("FAIL store_lanes: got %h/%b want cafe1200/0", d, e); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] d; logic e;
        do_req(M_XRD, MT_W, 32'h6, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b1) begin n_fail++;
            $display("FAIL misaligned_w: got %h/%b want 0/1", d, e); end
        n_checks++;
        if (ll_addr !== 32'hC) begin n_fail++;
            $display("FAIL err_last_addr: got %h want c", ll_addr); end
        do_req(M_XRD, MT_HU, 32'h9, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b1) begin n_fail++;
            $display("FAIL misaligned_h: got %h/%b want 0/1", d, e); end
        do_req(M_XRD, 3'd4, 32'h8, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b1) begin n_fail++;
            $display("FAIL illegal_typ: got %h/%b want 0/1", d, e); end
        do_req(M_XWR, MT_W, 32'h40, 32'h11111111, lat, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b1) begin n_fail++;
            $display("FAIL range_store: got %h/%b want 0/1", d, e); end
        do_req(M_XRD, MT_W, 32'h0, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b0) begin n_fail++;
            $display("FAIL range_no_write: got %h/%b want 0/0", d, e); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] d; logic e;
        req_valid = 1'b1; req_fcn = M_XRD; req_typ = MT_W; req_addr = 32'h8;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid = 1'b1; req_fcn = M_XWR; req_typ = MT_W;
                req_addr = 32'h8; req_data = 32'h0;
            end
            n_checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF
                || req_ready !== 1'b0) begin n_fail++;
                $display("FAIL hold_resp[%0d]: got v=%b d=%h rdy=%b want 1/deadbeef/0",
                         i, resp_valid, resp_data, req_ready); end
            @(posedge clock); #1;
        end
        req_valid = 1'b1; req_fcn = M_XRD; req_typ = MT_W; req_addr = 32'hC;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
            $display("FAIL turnaround_idle: got v=%b rdy=%b want 0/1",
                     resp_valid, req_ready); end
        @(posedge clock); #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++;
            $display("FAIL turnaround_accept: got %b want 0", req_ready); end
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
        n_checks++;
        if (lat != 2 || resp_data !== 32'hCAFE1200) begin n_fail++;
            $display("FAIL turnaround_load: got lat=%0d d=%h want 2/cafe1200",
                     lat, resp_data); end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        do_req(M_XRD, MT_W, 32'h8, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL ignored_store: got %h want deadbeef", d); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] d; logic e;
        req_valid = 1'b1; req_fcn = M_XWR; req_typ = MT_W;
        req_addr = 32'h4; req_data = 32'h12345678;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ll_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy=%b v=%b ll=%b want 1/0/0",
                     req_ready, resp_valid, ll_valid); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (ll_valid !== 1'b0 || resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_idle: got ll=%b v=%b want 0/0", ll_valid, resp_valid); end
        do_req(M_XRD, MT_W, 32'h4, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b0) begin n_fail++;
            $display("FAIL abandoned_store: got %h/%b want 0/0", d, e); end
        n_checks++;
        if (ll_valid !== 1'b1 || ll_addr !== 32'h4) begin n_fail++;
            $display("FAIL reload_last: got %b/%h want 1/4", ll_valid, ll_addr); end
        do_req(M_XRD, MT_W, 32'h8, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h0) begin n_fail++;
            $display("FAIL mem_cleared: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_subword_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
